rx_fifo: RTL and testbench

- Receive buffer sitting directly downstream of the serial `rx` block. Consumes its `flag`/`char0` handshake, acknowledges each character by pulsing `rx`'s `clear_flag`, and queues characters in a DEPTH-entry FIFO.
- Presents the oldest character and a ready flag to the keyboard IOT logic (KSF/KRB/KCC), so bursts from the host are not lost while the CPU is slow to service the flag.

---
 rtl/rx_fifo_pkg.sv | 16 +
 rtl/rx_fifo_mem.sv | 31 +++
 rtl/rx_fifo.sv | 131 +++++++++++++
 tb/tb_rx_fifo.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rx_fifo_pkg.sv
// Shared constants and types for the receive character FIFO.
// Character width, default depth/pointer width, handshake FSM state encoding.
// Imported by rx_fifo and rx_fifo_mem.
package rx_fifo_pkg;

    localparam int CHAR_W         = 8;
    localparam int RX_FIFO_DEPTH  = 16;
    localparam int RX_FIFO_ADDR_W = 4;

    // Handshake toward the serial rx block.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } rx_hs_state_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// Character storage for rx_fifo: DEPTH x CHAR_W array, sync write, async read.
// Latency: write visible on rd_data the cycle after the write edge; read is combinational.
// Backpressure: none; the caller gates wr_en.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr -> rd_data read port.
module rx_fifo_mem
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH  = RX_FIFO_DEPTH,
    parameter int ADDR_W = RX_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [0:CHAR_W-1] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [0:CHAR_W-1] rd_data
);

    // No reset: contents are only meaningful where the occupancy count says so,
    // and leaving it reset-free lets the array map onto LUT RAM.
    logic [0:CHAR_W-1] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rx_fifo.sv
// Receive FIFO behind the serial rx block: acks each rx character once, queues it, presents oldest to KSF/KRB.
// Latency: a captured character appears on rd_char/rd_flag one cycle after capture; pops advance rd_char next edge.
// Backpressure: none toward rx; a character arriving while full (and no same-cycle pop) is dropped and sets overrun.
// Ports: clk, reset (async active-low), clear (sync); rx_flag/rx_char/rx_clear_flag to rx;
//        rd_flag/rd_char/rd_strobe/count to the IOT logic; overrun/clear_overrun sticky drop flag.
module rx_fifo
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH  = RX_FIFO_DEPTH,
    parameter int ADDR_W = RX_FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              rx_flag,
    input  logic [0:CHAR_W-1] rx_char,
    output logic              rx_clear_flag,
    output logic              rd_flag,
    output logic [0:CHAR_W-1] rd_char,
    input  logic              rd_strobe,
    output logic [0:ADDR_W]   count,
    output logic              overrun,
    input  logic              clear_overrun
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    rx_hs_state_t      state, state_nx;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
    logic [ADDR_W:0]   cnt, cnt_nx, cnt_after_pop;
    logic              wr_req, wr_ok, pop_ok, drop;
    logic [0:CHAR_W-1] mem_rd_data, rd_char_q;
    logic              rd_flag_q, overrun_q;

    // Handshake FSM: one capture per rx flag assertion.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wr_req   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_flag) begin
                    wr_req   = 1'b1;
                    state_nx = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!rx_flag) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (clear) begin
            wr_req   = 1'b0;
            state_nx = ST_IDLE;
        end
    end

    // Decoded from the state register so reset drops it asynchronously.
    assign rx_clear_flag = (state == ST_ACK);

    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign pop_ok        = rd_strobe && (cnt != '0) && !clear;
    assign wr_ok         = wr_req && ((cnt != FULL_CNT) || rd_strobe);
    assign drop          = wr_req && !wr_ok;
    assign cnt_after_pop = cnt - (ADDR_W+1)'(pop_ok);
    assign cnt_nx        = cnt_after_pop + (ADDR_W+1)'(wr_ok);
    assign rd_ptr_nx     = rd_ptr + ADDR_W'(pop_ok);

    rx_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr),
        .wr_data (rx_char),
        .rd_addr (rd_ptr_nx),
        .rd_data (mem_rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            rd_flag_q <= 1'b0;
            rd_char_q <= '0;
            overrun_q <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            rd_flag_q <= 1'b0;
            rd_char_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            rd_ptr    <= rd_ptr_nx;
            cnt       <= cnt_nx;
            rd_flag_q <= (cnt_nx != '0);
            // Registered head: when the only surviving entry is the one being
            // written now, the array has not been updated yet, so bypass rx_char.
            if (cnt_nx != '0) begin
                rd_char_q <= (cnt_after_pop == '0) ? rx_char : mem_rd_data;
            end
            // Set beats clear when both happen in one cycle.
            if (drop) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign rd_flag = rd_flag_q;
    assign rd_char = rd_char_q;
    assign count   = cnt;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_rx_fifo.sv
module tb_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic          clk;
    logic          reset;
    logic          clear;
    logic          rx_flag;
    logic [0:7]    rx_char;
    logic          rx_clear_flag;
    logic          rd_flag;
    logic [0:7]    rd_char;
    logic          rd_strobe;
    logic [0:ADDR_W] count;
    logic          overrun;
    logic          clear_overrun;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a queue of characters plus handshake/overrun bits.
    logic [7:0] q[$];
    bit         ovr_m;
    bit         busy_m;

    rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .rx_flag       (rx_flag),
        .rx_char       (rx_char),
        .rx_clear_flag (rx_clear_flag),
        .rd_flag       (rd_flag),
        .rd_char       (rd_char),
        .rd_strobe     (rd_strobe),
        .count         (count),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovr_m  = 1'b0;
        busy_m = 1'b0;
    endtask

    task automatic model_update(input bit f, input logic [7:0] c, input bit pop,
                                input bit clr, input bit clro);
        bit cap, acc;
        if (clr) begin
            model_reset();
            return;
        end
        cap = f && !busy_m;
        acc = cap && ((q.size() < DEPTH) || pop);
        if (pop && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(c);
        if (cap && !acc) ovr_m = 1'b1;
        else if (clro)   ovr_m = 1'b0;
        busy_m = cap || (busy_m && f);
    endtask

    task automatic compare_all();
        check("count", int'(count), q.size());
        check("rd_flag", int'(rd_flag), int'(q.size() != 0));
        if (q.size() != 0) check("rd_char", int'(rd_char), int'(q[0]));
        check("overrun", int'(overrun), int'(ovr_m));
        check("rx_clear_flag", int'(rx_clear_flag), int'(busy_m));
    endtask

    // Drive one cycle of inputs at the falling edge, model the rising edge,
    // compare at the next falling edge.
    task automatic step(input bit f, input logic [7:0] c, input bit pop,
                        input bit clr, input bit clro);
        rx_flag       = f;
        rx_char       = c;
        rd_strobe     = pop;
        clear         = clr;
        clear_overrun = clro;
        @(posedge clk);
        model_update(f, c, pop, clr, clro);
        @(negedge clk);
        compare_all();
    endtask

    // rx-like sender: flag held two cycles, then dropped for one.
    task automatic send(input logic [7:0] c, input bit pop_first);
        step(1'b1, c, pop_first, 1'b0, 1'b0);
        step(1'b1, c, 1'b0, 1'b0, 1'b0);
        step(1'b0, c, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] burst [3];
        logic [7:0] v;
        bit         f, p, co, cl;

        reset = 1'b0; clear = 1'b0; rx_flag = 1'b0; rx_char = '0;
        rd_strobe = 1'b0; clear_overrun = 1'b0;
        model_reset();

        // Reset held for 100 ns.
        repeat (10) @(negedge clk);
        check("rst_count", int'(count), 0);
        check("rst_rd_flag", int'(rd_flag), 0);
        check("rst_rd_char", int'(rd_char), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_clear_flag", int'(rx_clear_flag), 0);
        reset = 1'b1;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Single character.
        send(8'o200, 1'b0);
        check("single_char", int'(rd_char), 8'o200);
        check("single_count", int'(count), 1);
        pop_one();
        check("single_empty", int'(rd_flag), 0);

        // Ordered burst.
        burst[0] = 8'o200; burst[1] = 8'o300; burst[2] = 8'o017;
        for (int i = 0; i < 3; i++) send(burst[i], 1'b0);
        check("burst_count", int'(count), 3);
        for (int i = 0; i < 3; i++) begin
            check("burst_order", int'(rd_char), int'(burst[i]));
            pop_one();
        end
        check("burst_empty", int'(rd_flag), 0);

        // Fill and overflow.
        for (int i = 0; i <= 16; i++) send(8'(i), 1'b0);
        check("full_count", int'(count), 16);
        check("full_overrun", int'(overrun), 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("overrun_cleared", int'(overrun), 0);

        // Write at full with a simultaneous pop.
        send(8'o123, 1'b1);
        check("fullpop_count", int'(count), 16);
        check("fullpop_overrun", int'(overrun), 0);
        for (int i = 1; i <= 16; i++) begin
            v = (i == 16) ? 8'o123 : 8'(i);
            check("full_drain", int'(rd_char), int'(v));
            pop_one();
        end

        // Push/pop across pointer wrap.
        for (int i = 0; i < 40; i++) begin
            v = 8'(i * 7 + 3);
            send(v, 1'b0);
            check("wrap_data", int'(rd_char), int'(v));
            pop_one();
        end

        // Clear discards content.
        for (int i = 0; i < 3; i++) send(8'(8'hA0 + i), 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("clear_count", int'(count), 0);
        check("clear_rd_flag", int'(rd_flag), 0);
        check("clear_ack_idle", int'(rx_clear_flag), 0);
        pop_one();
        check("empty_pop_count", int'(count), 0);

        // Reset in the middle of a handshake.
        step(1'b1, 8'h5a, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        check("rst_async_clear_flag", int'(rx_clear_flag), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 8'h5a, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h5a, 1'b0, 1'b0, 1'b0);
        check("rst_recapture", int'(rd_char), 8'h5a);
        pop_one();

        // Randomised traffic, alternating slow and fast readers.
        for (int i = 0; i < 3000; i++) begin
            f  = ($urandom_range(0, 2) != 0);
            v  = 8'($urandom);
            if ((i / 400) % 2 == 0) p = ($urandom_range(0, 7) == 0);
            else                    p = ($urandom_range(0, 1) == 0);
            co = ($urandom_range(0, 63) == 0);
            cl = ($urandom_range(0, 511) == 0);
            step(f, v, p, cl, co);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
